fix_value_decoder: RTL and testbench

- Downstream consumer of the parser top level's value-RAM read path.
- Takes a 256-bit ASCII FIX field value, such as a price or quantity, when the value-valid strobe fires.
- Walks the value one character per cycle and produces a signed 64-bit binary integer, a decimal scale (count of fractional digits) and error flags.
- Lets tag values (e.g. 44=Price, 38=OrderQty) be consumed numerically by later stages.

---
 rtl/fix_value_pkg.sv | 20 ++
 rtl/fix_dec_mac.sv | 27 ++
 rtl/fix_value_decoder.sv | 194 +++++++++++++++++++
 tb/tb_fix_value_decoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_value_pkg.sv
// Shared constants for the FIX ASCII value decoder: FSM encodings,
// error-flag bit positions and the ASCII characters the scanner recognises.
package fix_value_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    localparam int ERR_EMPTY = 0;
    localparam int ERR_CHAR  = 1;
    localparam int ERR_OVF   = 2;
    localparam int ERR_DOT   = 3;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

endpackage

// File: rtl/fix_dec_mac.sv
// Decimal multiply-accumulate step: acc*10 + digit, with overflow detection
// against the signed range limit selected by the sign of the value.
module fix_dec_mac #(
    parameter int RESULT_WIDTH = 64
) (
    input  logic [RESULT_WIDTH-1:0] acc,
    input  logic [3:0]              digit,
    input  logic                    neg,
    output logic [RESULT_WIDTH-1:0] acc_next,
    output logic                    ovf
);

    localparam int WW = RESULT_WIDTH + 4;
    // Magnitude of the most negative value; positives may reach one less.
    localparam logic [WW-1:0] NEG_LIMIT = WW'(1) << (RESULT_WIDTH - 1);

    logic [WW-1:0] wide;
    logic [WW-1:0] limit;

    always_comb begin
        wide     = {4'b0000, acc} * WW'(10) + {{(WW-4){1'b0}}, digit};
        limit    = neg ? NEG_LIMIT : (NEG_LIMIT - WW'(1));
        ovf      = (wide > limit);
        acc_next = wide[RESULT_WIDTH-1:0];
    end

endmodule

// File: rtl/fix_value_decoder.sv
// Converts a left-aligned ASCII FIX value (price, quantity) into a signed
// integer plus decimal scale, scanning one character per clock.
module fix_value_decoder
    import fix_value_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int RESULT_WIDTH = 64,
    parameter int MAX_CHARS    = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   value_i,
    input  logic                    value_valid_i,
    output logic                    busy_o,
    output logic [RESULT_WIDTH-1:0] result_o,
    output logic [4:0]              scale_o,
    output logic [3:0]              err_o,
    output logic                    result_valid_o,
    output logic                    overrun_o,
    output logic [1:0]              state_o
);

    // Handshake: value_valid_i is a single-cycle strobe accepted only while
    // busy_o is low; a strobe while busy is dropped and flagged on overrun_o.
    // result_valid_o is a one-cycle pulse with no backpressure.

    localparam int CNT_W = $clog2(MAX_CHARS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CHARS - 1);

    logic [1:0]              state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [RESULT_WIDTH-1:0] acc;
    logic                    neg;
    logic                    dot;
    logic                    digit_seen;
    logic [4:0]              scale;
    logic [CNT_W-1:0]        cnt;
    logic [RESULT_WIDTH-1:0] fin_result;
    logic [4:0]              fin_scale;
    logic [3:0]              fin_err;

    logic [7:0]              cur_byte;
    logic                    is_digit;
    logic [RESULT_WIDTH-1:0] mac_acc;
    logic                    mac_ovf;

    logic [RESULT_WIDTH-1:0] nxt_acc;
    logic                    nxt_neg;
    logic                    nxt_dot;
    logic                    nxt_seen;
    logic [4:0]              nxt_scale;
    logic [3:0]              step_err;
    logic                    stop;
    logic [3:0]              term_err;
    logic [RESULT_WIDTH-1:0] term_result;
    logic [4:0]              term_scale;

    assign cur_byte = shreg[DATA_WIDTH-1 -: 8];
    assign is_digit = (cur_byte >= ASCII_0) && (cur_byte <= ASCII_9);
    assign busy_o   = (state != ST_IDLE);
    assign state_o  = state;

    // ASCII digits 0x30..0x39 carry their value in the low nibble.
    fix_dec_mac #(
        .RESULT_WIDTH(RESULT_WIDTH)
    ) u_mac (
        .acc      (acc),
        .digit    (cur_byte[3:0]),
        .neg      (neg),
        .acc_next (mac_acc),
        .ovf      (mac_ovf)
    );

    always_comb begin
        nxt_acc   = acc;
        nxt_neg   = neg;
        nxt_dot   = dot;
        nxt_seen  = digit_seen;
        nxt_scale = scale;
        step_err  = 4'b0000;
        stop      = (cnt == LAST_CNT);
        if (cur_byte == ASCII_MINUS) begin
            if (cnt == '0) begin
                nxt_neg = 1'b1;
            end else begin
                step_err[ERR_CHAR] = 1'b1;
                stop               = 1'b1;
            end
        end else if (is_digit) begin
            if (mac_ovf) begin
                step_err[ERR_OVF] = 1'b1;
                stop              = 1'b1;
            end else begin
                nxt_acc  = mac_acc;
                nxt_seen = 1'b1;
                if (dot && (scale != 5'd31)) begin
                    nxt_scale = scale + 5'd1;
                end
            end
        end else if (cur_byte == ASCII_DOT) begin
            if (dot) begin
                step_err[ERR_DOT] = 1'b1;
                stop              = 1'b1;
            end else begin
                nxt_dot = 1'b1;
            end
        end else if (cur_byte == ASCII_NUL) begin
            stop = 1'b1;
        end else begin
            step_err[ERR_CHAR] = 1'b1;
            stop               = 1'b1;
        end
    end

    always_comb begin
        term_err = step_err;
        if (!nxt_seen && (step_err == 4'b0000)) begin
            term_err[ERR_EMPTY] = 1'b1;
        end
        if (term_err != 4'b0000) begin
            term_result = '0;
            term_scale  = 5'd0;
        end else begin
            term_result = nxt_neg ? (-nxt_acc) : nxt_acc;
            term_scale  = nxt_scale;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            shreg          <= '0;
            acc            <= '0;
            neg            <= 1'b0;
            dot            <= 1'b0;
            digit_seen     <= 1'b0;
            scale          <= 5'd0;
            cnt            <= '0;
            fin_result     <= '0;
            fin_scale      <= 5'd0;
            fin_err        <= 4'b0000;
            result_o       <= '0;
            scale_o        <= 5'd0;
            err_o          <= 4'b0000;
            result_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            result_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (value_valid_i) begin
                        shreg      <= value_i;
                        acc        <= '0;
                        neg        <= 1'b0;
                        dot        <= 1'b0;
                        digit_seen <= 1'b0;
                        scale      <= 5'd0;
                        cnt        <= '0;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    overrun_o  <= value_valid_i;
                    shreg      <= {shreg[DATA_WIDTH-9:0], 8'h00};
                    cnt        <= cnt + 1'b1;
                    acc        <= nxt_acc;
                    neg        <= nxt_neg;
                    dot        <= nxt_dot;
                    digit_seen <= nxt_seen;
                    scale      <= nxt_scale;
                    if (stop) begin
                        fin_result <= term_result;
                        fin_scale  <= term_scale;
                        fin_err    <= term_err;
                        state      <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    overrun_o      <= value_valid_i;
                    result_o       <= fin_result;
                    scale_o        <= fin_scale;
                    err_o          <= fin_err;
                    result_valid_o <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_value_decoder.sv
// Directed bench for fix_value_decoder: a string-level reference model feeds
// an expected queue that a per-cycle compare process checks against the DUT.
module tb_fix_value_decoder;
    import fix_value_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] value_i = '0;
    logic         value_valid_i = 1'b0;
    logic         busy_o;
    logic [63:0]  result_o;
    logic [4:0]   scale_o;
    logic [3:0]   err_o;
    logic         result_valid_o;
    logic         overrun_o;
    logic [1:0]   state_o;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int cur_t    = -1;
    int cur_end  = -2;
    int ovr_cyc  = -1;

    // {expected pulse cycle[104:73], err[72:69], scale[68:64], result[63:0]}
    logic [104:0] exp_q[$];

    fix_value_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .value_i        (value_i),
        .value_valid_i  (value_valid_i),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .scale_o        (scale_o),
        .err_o          (err_o),
        .result_valid_o (result_valid_o),
        .overrun_o      (overrun_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] mkval(input string s);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < 32; i++) v[255-8*i -: 8] = s[i];
        return v;
    endfunction

    // Returns {n[80:73], err[72:69], scale[68:64], result[63:0]}.
    function automatic logic [80:0] model(input logic [255:0] v);
        logic [127:0] mag;
        logic [127:0] lim;
        logic [7:0]   c;
        logic [3:0]   err;
        logic [63:0]  res;
        bit           neg, dot, seen;
        int           sc, n;
        mag = 0; neg = 0; dot = 0; seen = 0; sc = 0; n = 0; err = 0;
        for (int i = 0; i < 32; i++) begin
            c = v[255-8*i -: 8];
            n = i + 1;
            if (c == 8'h00) break;
            if (c == 8'h2D && i == 0) begin
                neg = 1;
                continue;
            end
            if (c >= 8'h30 && c <= 8'h39) begin
                mag = mag * 10 + 128'(c - 8'h30);
                lim = neg ? 128'h8000_0000_0000_0000 : 128'h7FFF_FFFF_FFFF_FFFF;
                if (mag > lim) begin
                    err[2] = 1;
                    break;
                end
                seen = 1;
                if (dot && sc < 31) sc++;
                continue;
            end
            if (c == 8'h2E) begin
                if (dot) begin
                    err[3] = 1;
                    break;
                end
                dot = 1;
                continue;
            end
            err[1] = 1;
            break;
        end
        if (err == 0 && !seen) err[0] = 1;
        if (err != 0) begin
            res = 0;
            sc  = 0;
        end else begin
            res = neg ? (64'd0 - mag[63:0]) : mag[63:0];
        end
        return {n[7:0], err, sc[4:0], res};
    endfunction

    // Drives one strobe at the current (negedge) time and releases it a cycle later.
    task automatic strobe(input string s);
        logic [255:0] v;
        logic [80:0]  m;
        int           t, n;
        v = mkval(s);
        m = model(v);
        n = int'(m[80:73]);
        value_i       = v;
        value_valid_i = 1'b1;
        if (cyc >= cur_t && cyc <= cur_end) begin
            ovr_cyc = cyc + 1;
        end else begin
            t       = cyc + 1;
            cur_t   = t;
            cur_end = t + n;
            exp_q.push_back({32'(t + n + 1), m[72:0]});
        end
        @(negedge clk);
        value_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run(input string s);
        strobe(s);
        wait_done();
    endtask

    always @(negedge clk) begin
        logic [104:0] e;
        if (rst) begin
            chk("busy", 64'(busy_o), 64'(cyc >= cur_t && cyc <= cur_end));
            chk("overrun", 64'(overrun_o), 64'(cyc == ovr_cyc));
            if (result_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(result_valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 64'(cyc), 64'(e[104:73]));
                    chk("result", result_o, e[63:0]);
                    chk("scale", 64'(scale_o), 64'(e[68:64]));
                    chk("err", 64'(err_o), 64'(e[72:69]));
                end
            end else if (exp_q.size() != 0 && cyc >= int'(exp_q[0][104:73])) begin
                chk("missed_valid", 64'(result_valid_o), 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        string       s9;
        logic [80:0] m;
        int          k;

        s9 = "";
        for (int i = 0; i < 32; i++) s9 = {s9, "9"};

        // Pin the model against hand-computed values.
        m = model(mkval("123"));
        chk("model_123", {m[80:73], m[72:69], m[68:64], m[63:0]} , {8'd4, 4'd0, 5'd0, 64'd123});
        m = model(mkval("-45.67"));
        chk("model_neg_res", m[63:0], 64'hFFFF_FFFF_FFFF_EE29);
        chk("model_neg_sc", 64'({m[80:73], m[68:64]}), 64'({8'd7, 5'd2}));
        m = model(mkval(s9));
        chk("model_ovf", 64'({m[80:73], m[72:69]}), 64'({8'd19, 4'b0100}));
        m = model(mkval("-9223372036854775808"));
        chk("model_min", m[63:0], 64'h8000_0000_0000_0000);
        m = model(mkval("12a4"));
        chk("model_char", 64'({m[80:73], m[72:69]}), 64'({8'd3, 4'b0010}));
        m = model(mkval("1.2.3"));
        chk("model_dot", 64'(m[72:69]), 64'b1000);
        m = model(mkval(""));
        chk("model_empty", 64'({m[80:73], m[72:69]}), 64'({8'd1, 4'b0001}));
        m = model(mkval("-"));
        chk("model_minus", 64'(m[72:69]), 64'b0001);

        // Reset state.
        #1 rst = 1'b0;
        #11;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_valid", 64'(result_valid_o), 64'd0);
        chk("rst_overrun", 64'(overrun_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_scale", 64'(scale_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_state", 64'(state_o), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run("123");
        chk("lit_123", result_o, 64'd123);
        run("-45.67");
        chk("lit_neg", result_o, 64'hFFFF_FFFF_FFFF_EE29);
        chk("lit_neg_scale", 64'(scale_o), 64'd2);
        run(s9);
        chk("lit_ovf_err", 64'(err_o), 64'b0100);
        run("-9223372036854775808");
        chk("lit_min", result_o, 64'h8000_0000_0000_0000);
        run("9223372036854775807");
        run("9223372036854775808");
        run("12a4");
        chk("lit_char", 64'(err_o), 64'b0010);
        run("1.2.3");
        run("");
        chk("lit_empty", 64'(err_o), 64'b0001);
        run("-");
        run("1-2");
        run(".5");
        run("12.");
        run("007");
        run("0000000000000000000000000000.123");
        chk("lit_full", result_o, 64'd123);

        // Overrun while busy, then a strobe in the result_valid cycle.
        strobe("55");
        @(negedge clk);
        strobe("11");
        k = 0;
        while (!result_valid_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        strobe("321");
        wait_done();
        chk("lit_b2b", result_o, 64'd321);

        // Asynchronous reset mid-scan.
        strobe("98765");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", 64'(busy_o), 64'd0);
        chk("mid_result", result_o, 64'd0);
        chk("mid_valid", 64'(result_valid_o), 64'd0);
        chk("mid_err", 64'(err_o), 64'd0);
        exp_q.delete();
        cur_t   = -1;
        cur_end = -2;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        strobe("7");
        wait_done();
        chk("lit_7", result_o, 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
